fpu_issue_ctrl: RTL and testbench

- Sequences a multi-cycle floating-point unit that sits beside the integer ALU in the execute stage.
- Accepts one FP operation at a time from the ID/EX boundary and holds the FPU operands and opcode stable for the FPU's full latency.
- Stalls the front of the pipeline while the FPU is busy.
- Presents the captured result, with its destination register, to the EX/MEM boundary under a hold-while-stalled rule.

---
 rtl/fpu_issue_ctrl.sv | 167 ++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: runs one multi-cycle FPU operation at a time beside the integer ALU.
// Latency: an issue taken at edge T makes result_valid high from cycle T+LATENCY+1.
// Backpressure: stall freezes IF/ID/EX while the op runs; the result is held in DONE while downstream_stall.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   issue_valid/op/a/b/waddr   FP instruction sitting in the execute register
//   flush                      squash the in-flight op (branch or exception)
//   downstream_stall           MEM stage cannot take a result this cycle
//   fpu_result                 FPU output, valid LATENCY cycles after its operands settle
//   fpu_a/fpu_b/fpu_op         registered operands and opcode, held for the whole FPU run
//   stall                      combinational hold request to the front of the pipeline
//   busy                       registered, high while an op is running or its result is waiting
//   result_valid/result/result_waddr   captured result presented to EX/MEM
//
// Parameters: LATENCY is 1..15 FPU cycles. CNT_W must be wide enough to hold LATENCY-1.

module fpu_issue_ctrl #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [2:0]  issue_op,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [5:0]  issue_waddr,
  input  logic        flush,
  input  logic        downstream_stall,
  input  logic [31:0] fpu_result,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [2:0]  fpu_op,
  output logic        stall,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [5:0]  result_waddr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The counter runs from LATENCY-1 down to 0, which gives exactly LATENCY cycles in EXEC.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       fpu_a_q, fpu_a_d;
  logic [31:0]       fpu_b_q, fpu_b_d;
  logic [2:0]        fpu_op_q, fpu_op_d;
  logic [31:0]       result_q, result_d;
  logic [5:0]        result_waddr_q, result_waddr_d;
  logic              busy_q, busy_d;
  logic              result_valid_q, result_valid_d;
  logic              issue_accept;

  // A flush in the same cycle as an issue wins, so the instruction is never started.
  assign issue_accept = (state_q == S_IDLE) && issue_valid && !flush;

  // Next-state and datapath-capture logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    fpu_a_d        = fpu_a_q;
    fpu_b_d        = fpu_b_q;
    fpu_op_d       = fpu_op_q;
    result_d       = result_q;
    result_waddr_d = result_waddr_q;

    case (state_q)
      S_IDLE: begin
        if (issue_accept) begin
          fpu_a_d        = issue_a;
          fpu_b_d        = issue_b;
          fpu_op_d       = issue_op;
          result_waddr_d = issue_waddr;
          cnt_d          = CNT_LOAD;
          state_d        = S_EXEC;
        end
      end

      S_EXEC: begin
        // The FPU operands stay untouched here. A flush drops the op and the
        // result register keeps whatever it last held.
        if (flush) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          result_d = fpu_result;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        // A flush takes the same exit as a handoff. The result is never
        // consumed, but result_valid still drops on the next cycle.
        if (flush || !downstream_stall) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state, so they do not
    // depend combinationally on any input.
    busy_d         = (state_d != S_IDLE);
    result_valid_d = (state_d == S_DONE);
  end

  // The front end is held while an issue is being taken, while the FPU runs,
  // and while a finished result is blocked downstream. In the DONE cycle that
  // hands off, stall is low so the next instruction moves into execute.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      S_IDLE:  stall = issue_accept;
      S_EXEC:  stall = 1'b1;
      S_DONE:  stall = downstream_stall;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      fpu_a_q        <= '0;
      fpu_b_q        <= '0;
      fpu_op_q       <= '0;
      result_q       <= '0;
      result_waddr_q <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      fpu_a_q        <= fpu_a_d;
      fpu_b_q        <= fpu_b_d;
      fpu_op_q       <= fpu_op_d;
      result_q       <= result_d;
      result_waddr_q <= result_waddr_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign fpu_a        = fpu_a_q;
  assign fpu_b        = fpu_b_q;
  assign fpu_op       = fpu_op_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign result_waddr = result_waddr_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: bench for fpu_issue_ctrl. It builds a LATENCY=4 instance and a LATENCY=1 instance.
// Each task drives stimulus and checks the outputs at the falling edge.
// A cycle-level reference model and an FPU behavioural model produce every expected value.

module tb_fpu_issue_ctrl;

  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Signals for the LATENCY=4 instance.
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_op = '0;
  logic [31:0] issue_a = '0, issue_b = '0;
  logic [5:0]  issue_waddr = '0;
  logic        flush = 1'b0, downstream_stall = 1'b0;
  logic [31:0] fpu_result = '0;
  logic [31:0] fpu_a, fpu_b, result;
  logic [2:0]  fpu_op;
  logic [5:0]  result_waddr;
  logic        stall, busy, result_valid;

  // Signals for the LATENCY=1 instance. It shares the same reset.
  logic        l1_issue_valid = 1'b0;
  logic [2:0]  l1_issue_op = '0;
  logic [31:0] l1_issue_a = '0, l1_issue_b = '0;
  logic [5:0]  l1_issue_waddr = '0;
  logic        l1_flush = 1'b0, l1_downstream_stall = 1'b0;
  logic [31:0] l1_fpu_result = '0;
  logic [31:0] l1_fpu_a, l1_fpu_b, l1_result;
  logic [2:0]  l1_fpu_op;
  logic [5:0]  l1_result_waddr;
  logic        l1_stall, l1_busy, l1_result_valid;

  fpu_issue_ctrl #(.LATENCY(LAT), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_a(issue_a), .issue_b(issue_b), .issue_waddr(issue_waddr), .flush(flush),
    .downstream_stall(downstream_stall), .fpu_result(fpu_result), .fpu_a(fpu_a),
    .fpu_b(fpu_b), .fpu_op(fpu_op), .stall(stall), .busy(busy),
    .result_valid(result_valid), .result(result), .result_waddr(result_waddr)
  );

  fpu_issue_ctrl #(.LATENCY(1), .CNT_W(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .issue_valid(l1_issue_valid), .issue_op(l1_issue_op),
    .issue_a(l1_issue_a), .issue_b(l1_issue_b), .issue_waddr(l1_issue_waddr), .flush(l1_flush),
    .downstream_stall(l1_downstream_stall), .fpu_result(l1_fpu_result), .fpu_a(l1_fpu_a),
    .fpu_b(l1_fpu_b), .fpu_op(l1_fpu_op), .stall(l1_stall), .busy(l1_busy),
    .result_valid(l1_result_valid), .result(l1_result), .result_waddr(l1_result_waddr)
  );

  // Single-precision helpers for positive normal operands. Rounding truncates.
  function automatic real f2r(input logic [31:0] x);
    real v;
    int  e;
    v = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return v;
  endfunction

  function automatic logic [31:0] r2f(input real v_in);
    real         v;
    int          e;
    logic [22:0] m;
    logic [7:0]  ev;
    v = v_in;
    e = 127;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    m  = 23'($rtoi((v - 1.0) * 8388608.0));
    ev = 8'(e);
    return {1'b0, ev, m};
  endfunction

  function automatic logic norm_pos(input logic [31:0] x);
    return !x[31] && (x[30:23] >= 8'd64) && (x[30:23] <= 8'd190);
  endfunction

  // Behavioural FPU: opcode 2 is a float add and the other opcodes are simple integer functions.
  function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return (norm_pos(a) && norm_pos(b)) ? r2f(f2r(a) + f2r(b)) : (a + b);
      3'd3: return a ^ b;
      3'd4: return a * b;
      3'd5: return {a[15:0], b[15:0]};
      3'd6: return a | b;
      default: return ~a;
    endcase
  endfunction

  function automatic logic [31:0] rand_norm();
    return {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  // The FPU output is valid only after its inputs have been stable for LAT cycles.
  // Before that it returns a recognisable garbage value.
  int          stable = 0;
  logic [66:0] prev_in = '0;
  always @(negedge clk) begin
    if ({fpu_op, fpu_a, fpu_b} !== prev_in) stable = 1;
    else stable = stable + 1;
    prev_in = {fpu_op, fpu_a, fpu_b};
    fpu_result = (stable >= LAT) ? fmodel(fpu_a, fpu_b, fpu_op) : (32'hDEAD0000 | 32'(stable));
  end

  always @(negedge clk) l1_fpu_result = fmodel(l1_fpu_a, l1_fpu_b, l1_fpu_op);

  // Reference model for the LATENCY=4 instance. It tracks how many execute
  // cycles remain and whether a finished result is waiting.
  int          m_exec = 0;
  bit          m_done = 0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic [2:0]  m_op = '0;
  logic [5:0]  m_wa = '0;

  // Returns the expected {stall, busy, result_valid} for the current cycle.
  function automatic logic [2:0] exp_flags();
    logic idle, st;
    idle = (m_exec == 0) && !m_done;
    st   = (idle && issue_valid && !flush) || (m_exec > 0) || (m_done && downstream_stall);
    return {st, !idle, m_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_exec = 0; m_done = 0;
      m_a = '0; m_b = '0; m_op = '0; m_wa = '0; m_res = '0;
    end else if (m_exec > 0) begin
      if (flush) m_exec = 0;
      else if (m_exec == 1) begin
        m_res  = fmodel(m_a, m_b, m_op);
        m_exec = 0;
        m_done = 1;
      end else m_exec--;
    end else if (m_done) begin
      if (flush || !downstream_stall) m_done = 0;
    end else if (issue_valid && !flush) begin
      m_a = issue_a; m_b = issue_b; m_op = issue_op; m_wa = issue_waddr;
      m_exec = LAT;
    end
    #1;
  endtask

  task automatic drive(input logic iv, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] wa, input logic fl, input logic ds);
    issue_valid = iv; issue_op = op; issue_a = a; issue_b = b;
    issue_waddr = wa; flush = fl; downstream_stall = ds;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    tick(); tick();
    @(negedge clk);
    total++;
    if ({fpu_a, fpu_b, fpu_op, result, result_waddr, result_valid, busy, stall} !== '0) begin
      bad++;
      $display("FAIL reset_l4 got a=%h b=%h op=%h r=%h wa=%h v=%b busy=%b stall=%b want all zero",
               fpu_a, fpu_b, fpu_op, result, result_waddr, result_valid, busy, stall);
    end
    total++;
    if ({l1_fpu_a, l1_fpu_b, l1_fpu_op, l1_result, l1_result_waddr, l1_result_valid, l1_busy, l1_stall} !== '0) begin
      bad++;
      $display("FAIL reset_l1 got r=%h v=%b busy=%b stall=%b want all zero",
               l1_result, l1_result_valid, l1_busy, l1_stall);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_op();
    for (int cyc = 0; cyc <= 6; cyc++) begin
      if (cyc == 0) drive(1'b1, 3'b010, 32'h3F800000, 32'h40000000, 6'd5, 1'b0, 1'b0);
      else drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if ({stall, busy, result_valid} !== {cyc <= 4, (cyc >= 1 && cyc <= 5), cyc == 5}) begin
        bad++;
        $display("FAIL single_flags cyc=%0d got=%b want=%b", cyc, {stall, busy, result_valid},
                 {cyc <= 4, (cyc >= 1 && cyc <= 5), cyc == 5});
      end
      if (cyc >= 1 && cyc <= 4) begin
        total++;
        if ({fpu_op, fpu_a, fpu_b} !== {3'b010, 32'h3F800000, 32'h40000000}) begin
          bad++;
          $display("FAIL single_operands cyc=%0d got op=%h a=%h b=%h want 2/3f800000/40000000",
                   cyc, fpu_op, fpu_a, fpu_b);
        end
      end
      if (cyc == 5) begin
        total++;
        if ({result, result_waddr} !== {32'h40400000, 6'd5}) begin
          bad++;
          $display("FAIL single_result got r=%h wa=%0d want r=40400000 wa=5", result, result_waddr);
        end
      end
      tick();
    end
  endtask

  task automatic test_hold();
    logic [31:0] a, b, er;
    logic [5:0]  wa;
    a = rand_norm(); b = rand_norm(); wa = 6'($urandom);
    er = fmodel(a, b, 3'd2);
    for (int cyc = 0; cyc <= 9; cyc++) begin
      logic [2:0] want;
      if (cyc == 0) drive(1'b1, 3'd2, a, b, wa, 1'b0, 1'b0);
      else drive(1'b0, '0, '0, '0, '0, 1'b0, (cyc >= 5 && cyc <= 7));
      want = {(cyc <= 7), (cyc >= 1 && cyc <= 8), (cyc >= 5 && cyc <= 8)};
      @(negedge clk);
      total++;
      if ({stall, busy, result_valid} !== want) begin
        bad++;
        $display("FAIL hold_flags cyc=%0d got=%b want=%b", cyc, {stall, busy, result_valid}, want);
      end
      if (cyc >= 5 && cyc <= 8) begin
        total++;
        if ({result, result_waddr} !== {er, wa}) begin
          bad++;
          $display("FAIL hold_result cyc=%0d got r=%h wa=%0d want r=%h wa=%0d", cyc, result, result_waddr, er, wa);
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [31:0] keep;
    keep = m_res;
    for (int cyc = 0; cyc <= 7; cyc++) begin
      logic [2:0] want;
      if (cyc == 0) drive(1'b1, 3'($urandom), $urandom, $urandom, 6'($urandom), 1'b0, 1'b0);
      else drive(1'b0, '0, '0, '0, '0, cyc == 2, 1'b0);
      want = {(cyc <= 2), (cyc >= 1 && cyc <= 2), 1'b0};
      @(negedge clk);
      total++;
      if ({stall, busy, result_valid} !== want || result !== keep) begin
        bad++;
        $display("FAIL flush cyc=%0d got flags=%b r=%h want flags=%b r=%h",
                 cyc, {stall, busy, result_valid}, result, want, keep);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ya, yb;
    logic [2:0]  yop;
    logic [5:0]  ywa;
    ya = $urandom; yb = $urandom; yop = 3'($urandom); ywa = 6'($urandom_range(1, 63));
    for (int cyc = 0; cyc <= 10; cyc++) begin
      logic [2:0] want;
      reset = (cyc == 3);
      if (cyc == 0) drive(1'b1, 3'd3, 32'h1234_5678, 32'h0F0F_0F0F, 6'd9, 1'b0, 1'b0);
      else if (cyc == 4) drive(1'b1, yop, ya, yb, ywa, 1'b0, 1'b0);
      else drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
      want = {(cyc <= 8), ((cyc >= 1 && cyc <= 3) || (cyc >= 5 && cyc <= 9)), cyc == 9};
      @(negedge clk);
      total++;
      if ({stall, busy, result_valid} !== want) begin
        bad++;
        $display("FAIL rstmid_flags cyc=%0d got=%b want=%b", cyc, {stall, busy, result_valid}, want);
      end
      if (cyc == 4) begin
        total++;
        if ({fpu_a, fpu_b, fpu_op, result, result_waddr, result_valid, busy} !== '0) begin
          bad++;
          $display("FAIL rstmid_zero got a=%h b=%h op=%h r=%h wa=%h v=%b busy=%b want all zero",
                   fpu_a, fpu_b, fpu_op, result, result_waddr, result_valid, busy);
        end
      end
      if (cyc == 9) begin
        total++;
        if ({result, result_waddr} !== {fmodel(ya, yb, yop), ywa}) begin
          bad++;
          $display("FAIL rstmid_result got r=%h wa=%0d want r=%h wa=%0d",
                   result, result_waddr, fmodel(ya, yb, yop), ywa);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ia[2], ib[2];
    logic [2:0]  iop[2];
    logic [5:0]  iwa[2];
    int idx;
    for (int k = 0; k < 2; k++) begin
      iop[k] = 3'($urandom); ia[k] = $urandom; ib[k] = $urandom; iwa[k] = 6'($urandom);
    end
    idx = 0;
    for (int cyc = 0; cyc <= 13; cyc++) begin
      logic [2:0] want;
      if (idx < 2) drive(1'b1, iop[idx], ia[idx], ib[idx], iwa[idx], 1'b0, 1'b0);
      else drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
      want = exp_flags();
      @(negedge clk);
      total++;
      if ({stall, busy, result_valid} !== want) begin
        bad++;
        $display("FAIL b2b_flags cyc=%0d got=%b want=%b", cyc, {stall, busy, result_valid}, want);
      end
      if (m_exec > 0) begin
        total++;
        if ({fpu_op, fpu_a, fpu_b} !== {m_op, m_a, m_b}) begin
          bad++;
          $display("FAIL b2b_operands cyc=%0d got a=%h b=%h want a=%h b=%h", cyc, fpu_a, fpu_b, m_a, m_b);
        end
      end
      if (cyc == 6) begin
        total++;
        if ({stall, busy, fpu_a} !== {1'b1, 1'b0, ia[0]}) begin
          bad++;
          $display("FAIL b2b_gap got stall=%b busy=%b a=%h want 1 0 %h", stall, busy, fpu_a, ia[0]);
        end
      end
      if (cyc == 7) begin
        total++;
        if (fpu_a !== ia[1]) begin
          bad++;
          $display("FAIL b2b_second_latch got a=%h want %h", fpu_a, ia[1]);
        end
      end
      if (cyc == 11) begin
        total++;
        if ({result_valid, result, result_waddr} !== {1'b1, fmodel(ia[1], ib[1], iop[1]), iwa[1]}) begin
          bad++;
          $display("FAIL b2b_second_result got v=%b r=%h want 1 %h", result_valid, result,
                   fmodel(ia[1], ib[1], iop[1]));
        end
      end
      // The execute register moves on only when the edge sees stall low.
      if (idx < 2 && !want[2]) idx++;
      tick();
    end
  endtask

  task automatic test_latency1();
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [3:0]  want[5];
    a = $urandom; b = $urandom; op = 3'($urandom);
    // {stall, busy, result_valid, result-matches}
    want[0] = 4'b1000; want[1] = 4'b1100; want[2] = 4'b0111; want[3] = 4'b0000; want[4] = 4'b0000;
    for (int cyc = 0; cyc <= 4; cyc++) begin
      l1_issue_valid = (cyc == 0) || (cyc == 3);
      l1_flush       = (cyc == 3);
      l1_issue_op = op; l1_issue_a = a; l1_issue_b = b; l1_issue_waddr = 6'd17;
      @(negedge clk);
      total++;
      if ({l1_stall, l1_busy, l1_result_valid, (cyc == 2) ? (l1_result === fmodel(a, b, op)) : 1'b0} !== want[cyc]) begin
        bad++;
        $display("FAIL lat1 cyc=%0d got stall=%b busy=%b v=%b r=%h want %b r=%h", cyc, l1_stall, l1_busy,
                 l1_result_valid, l1_result, want[cyc], fmodel(a, b, op));
      end
      tick();
    end
    l1_issue_valid = 1'b0; l1_flush = 1'b0;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [2:0] op, want;
      op = 3'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) < 6, op, (op == 3'd2) ? rand_norm() : $urandom,
            (op == 3'd2) ? rand_norm() : $urandom, 6'($urandom),
            $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 4);
      want = exp_flags();
      @(negedge clk);
      total++;
      if ({stall, busy, result_valid} !== want) begin
        bad++;
        $display("FAIL rand_flags cyc=%0d got=%b want=%b", cyc, {stall, busy, result_valid}, want);
      end
      total++;
      if ({fpu_op, fpu_a, fpu_b} !== {m_op, m_a, m_b}) begin
        bad++;
        $display("FAIL rand_operands cyc=%0d got %h/%h/%h want %h/%h/%h", cyc, fpu_op, fpu_a, fpu_b, m_op, m_a, m_b);
      end
      total++;
      if ({result, result_waddr} !== {m_res, m_wa}) begin
        bad++;
        $display("FAIL rand_result cyc=%0d got r=%h wa=%0d want r=%h wa=%0d", cyc, result, result_waddr, m_res, m_wa);
      end
      tick();
    end
    reset = 1'b0;
    drive(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_hold();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_latency1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
